hicore_trap_ctrl: RTL and testbench

Commit/trap controller between the ROB head and the CSR unit. It retires at most one ROB-head entry per cycle and drives the CSR unit's `commit_*` inputs. It decides when exceptions, interrupts, `mret`, CSR writes and `wfi` take effect, then issues a registered `flush` plus a `redirect_pc` to fetch. After each redirect it holds a fixed drain window.

---
 rtl/hicore_defines.sv | 25 ++
 rtl/hicore_trap_ctrl_if.sv | 49 ++++
 rtl/hicore_irq_pick.sv | 37 +++
 rtl/hicore_trap_ctrl.sv | 157 +++++++++++++++
 tb/tb_hicore_trap_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hicore_defines.sv
// Shared HiCore definitions: sizes, trap controller state encoding,
// machine interrupt bit positions and mtvec mode values.
package hicore_defines;

    localparam int unsigned HICORE_EXCP_SIZE = 16;
    localparam int unsigned HICORE_IRQ_SIZE  = 12;

    typedef enum logic [1:0] {
        TRAP_RUN   = 2'd0,
        TRAP_DRAIN = 2'd1,
        TRAP_WFI   = 2'd2
    } trap_state_e;

    localparam int unsigned IRQ_MEI = 11;
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
        return mtvec & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/hicore_trap_ctrl_if.sv
// ROB-head / CSR-commit bundle between the reorder buffer, the trap
// controller (slave) and the CSR unit.
interface hicore_trap_ctrl_if
    import hicore_defines::*;
#(
    parameter int unsigned EXCP_W = HICORE_EXCP_SIZE,
    parameter int unsigned IRQ_W  = HICORE_IRQ_SIZE
) ();

    logic              rob_head_valid;
    logic [EXCP_W-1:0] rob_head_excp;
    logic [31:0]       rob_head_pc;
    logic [31:0]       rob_head_next_pc;
    logic              rob_head_csr_need;
    logic [11:0]       rob_head_csr_idx;
    logic [31:0]       rob_head_csr_data;
    logic              rob_head_mret;
    logic              rob_head_wfi;
    logic              rob_head_pop;

    logic              commit_valid;
    logic [EXCP_W-1:0] commit_excp;
    logic [IRQ_W-1:0]  commit_irq;
    logic [31:0]       commit_pc;
    logic [31:0]       commit_next_pc;
    logic              commit_csr_need;
    logic [11:0]       commit_csr_idx;
    logic [31:0]       commit_csr_data;
    logic              commit_mret_op;

    modport master (
        output rob_head_valid, rob_head_excp, rob_head_pc, rob_head_next_pc,
               rob_head_csr_need, rob_head_csr_idx, rob_head_csr_data,
               rob_head_mret, rob_head_wfi,
        input  rob_head_pop,
        input  commit_valid, commit_excp, commit_irq, commit_pc, commit_next_pc,
               commit_csr_need, commit_csr_idx, commit_csr_data, commit_mret_op
    );

    modport slave (
        input  rob_head_valid, rob_head_excp, rob_head_pc, rob_head_next_pc,
               rob_head_csr_need, rob_head_csr_idx, rob_head_csr_data,
               rob_head_mret, rob_head_wfi,
        output rob_head_pop,
        output commit_valid, commit_excp, commit_irq, commit_pc, commit_next_pc,
               commit_csr_need, commit_csr_idx, commit_csr_data, commit_mret_op
    );

endinterface

// File: rtl/hicore_irq_pick.sv
// One-hot priority pick of the pending machine interrupt (MEI > MSI > MTI)
// and its cause number for vectored trap entry.
module hicore_irq_pick
    import hicore_defines::*;
#(
    parameter int unsigned IRQ_W = HICORE_IRQ_SIZE
) (
    input  logic [IRQ_W-1:0] pend,
    output logic [IRQ_W-1:0] irq_sel,
    output logic [3:0]       cause
);

    always_comb begin
        irq_sel = '0;
        cause   = '0;
        if (pend[IRQ_MEI]) begin
            irq_sel[IRQ_MEI] = 1'b1;
            cause            = 4'(IRQ_MEI);
        end else if (pend[IRQ_MSI]) begin
            irq_sel[IRQ_MSI] = 1'b1;
            cause            = 4'(IRQ_MSI);
        end else if (pend[IRQ_MTI]) begin
            irq_sel[IRQ_MTI] = 1'b1;
            cause            = 4'(IRQ_MTI);
        end else begin
            // Platform lines beyond the standard three: lowest index wins.
            for (int unsigned i = IRQ_W; i > 0; i--) begin
                if (pend[i-1]) begin
                    irq_sel      = '0;
                    irq_sel[i-1] = 1'b1;
                    cause        = 4'(i-1);
                end
            end
        end
    end

endmodule

// File: rtl/hicore_trap_ctrl.sv
// Commit/trap controller: retires the ROB head into the CSR unit, decides
// trap/mret/CSR/wfi redirects and holds a drain window after each flush.
module hicore_trap_ctrl
    import hicore_defines::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned EXCP_W       = HICORE_EXCP_SIZE,
    parameter int unsigned IRQ_W        = HICORE_IRQ_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    hicore_trap_ctrl_if.slave rob,
    input  logic              ext_irq,
    input  logic              sft_irq,
    input  logic              tmr_irq,
    input  logic [IRQ_W-1:0]  irq_msk,
    input  logic [31:0]       csr_mepc,
    input  logic [31:0]       csr_mtvec,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              fetch_stall
);

    trap_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic [31:0]       redir_q, redir_d;
    logic [IRQ_W-1:0]  irq_raw_q, irq_raw_d;

    logic [IRQ_W-1:0]  pend;
    logic [IRQ_W-1:0]  irq_sel;
    logic [3:0]        irq_cause;
    logic [EXCP_W-1:0] excp;
    logic              run, commit, has_excp, irq_ok;
    logic [31:0]       trap_base, irq_target;

    hicore_irq_pick #(
        .IRQ_W (IRQ_W)
    ) u_irq_pick (
        .pend    (pend),
        .irq_sel (irq_sel),
        .cause   (irq_cause)
    );

    always_comb begin
        irq_raw_d          = '0;
        irq_raw_d[IRQ_MEI] = ext_irq;
        irq_raw_d[IRQ_MSI] = sft_irq;
        irq_raw_d[IRQ_MTI] = tmr_irq;
    end

    assign pend      = irq_raw_q & irq_msk;
    assign excp      = rob.rob_head_excp;
    assign has_excp  = |excp;
    assign run       = (state_q == TRAP_RUN) && !rst;
    assign commit    = run && rob.rob_head_valid;
    assign irq_ok    = (|pend) && !has_excp && !rob.rob_head_mret && !rob.rob_head_csr_need;
    assign trap_base = mtvec_base(csr_mtvec);

    always_comb begin
        unique case (csr_mtvec[1:0])
            MTVEC_DIRECT:   irq_target = trap_base;
            MTVEC_VECTORED: irq_target = trap_base + {26'd0, irq_cause, 2'b00};
            default:        irq_target = trap_base;
        endcase
    end

    always_comb begin
        rob.rob_head_pop    = commit;
        rob.commit_valid    = commit;
        rob.commit_excp     = '0;
        rob.commit_irq      = '0;
        rob.commit_pc       = '0;
        rob.commit_next_pc  = '0;
        rob.commit_csr_need = 1'b0;
        rob.commit_csr_idx  = '0;
        rob.commit_csr_data = '0;
        rob.commit_mret_op  = 1'b0;
        if (run) begin
            rob.commit_excp     = excp;
            rob.commit_irq      = irq_ok ? irq_sel : '0;
            rob.commit_pc       = rob.rob_head_pc;
            rob.commit_next_pc  = rob.rob_head_next_pc;
            rob.commit_csr_need = rob.rob_head_csr_need;
            rob.commit_csr_idx  = rob.rob_head_csr_idx;
            rob.commit_csr_data = rob.rob_head_csr_data;
            rob.commit_mret_op  = rob.rob_head_mret;
        end
    end

    // The if-chain order is the event priority on a commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        redir_d = '0;
        unique case (state_q)
            TRAP_RUN: begin
                if (commit) begin
                    flush_d = 1'b1;
                    state_d = TRAP_DRAIN;
                    cnt_d   = 3'(FLUSH_CYCLES);
                    if (has_excp) begin
                        redir_d = trap_base;
                    end else if (irq_ok) begin
                        redir_d = irq_target;
                    end else if (rob.rob_head_mret) begin
                        redir_d = csr_mepc;
                    end else if (rob.rob_head_csr_need) begin
                        redir_d = rob.rob_head_next_pc;
                    end else if (rob.rob_head_wfi) begin
                        redir_d = rob.rob_head_next_pc;
                        state_d = TRAP_WFI;
                        cnt_d   = cnt_q;
                    end else begin
                        flush_d = 1'b0;
                        state_d = TRAP_RUN;
                        cnt_d   = cnt_q;
                    end
                end
            end
            TRAP_DRAIN: begin
                if (cnt_q <= 3'd1) begin
                    state_d = TRAP_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            TRAP_WFI: begin
                if (|irq_raw_q) state_d = TRAP_RUN;
            end
            default: state_d = TRAP_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TRAP_RUN;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            redir_q   <= '0;
            irq_raw_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            redir_q   <= redir_d;
            irq_raw_q <= irq_raw_d;
        end
    end

    assign flush       = flush_q && !rst;
    assign redirect_pc = rst ? '0 : redir_q;
    assign fetch_stall = (state_q == TRAP_WFI) && !rst;

endmodule

// File: tb/tb_hicore_trap_ctrl.sv
// Directed and randomized bench for hicore_trap_ctrl against a cycle-level
// reference model of the commit, redirect, drain and sleep rules.
module tb_hicore_trap_ctrl;
    import hicore_defines::*;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_irq, sft_irq, tmr_irq;
    logic [11:0] irq_msk;
    logic [31:0] csr_mepc, csr_mtvec;
    logic        flush, fetch_stall;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle index, first cycle a commit may happen again,
    // sleeping flag, expected flush cycle/target and the sampled irq lines.
    int          cyc        = 0;
    int          resume_cyc = 0;
    int          flush_at   = -1;
    bit          sleeping   = 1'b0;
    logic [31:0] flush_pc   = '0;
    logic [2:0]  lines_q    = '0;

    hicore_trap_ctrl_if #(.EXCP_W(16), .IRQ_W(12)) rob_bus ();

    hicore_trap_ctrl #(
        .FLUSH_CYCLES (FC),
        .EXCP_W       (16),
        .IRQ_W        (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rob         (rob_bus),
        .ext_irq     (ext_irq),
        .sft_irq     (sft_irq),
        .tmr_irq     (tmr_irq),
        .irq_msk     (irq_msk),
        .csr_mepc    (csr_mepc),
        .csr_mtvec   (csr_mtvec),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .fetch_stall (fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] irq_vec(input logic [2:0] l);
        logic [11:0] v;
        v     = '0;
        v[11] = l[2];
        v[3]  = l[1];
        v[7]  = l[0];
        return v;
    endfunction

    function automatic int hi_cause(input logic [11:0] p);
        if (p[11]) return 11;
        if (p[3])  return 3;
        if (p[7])  return 7;
        return -1;
    endfunction

    task automatic head(input logic v, input logic [15:0] e, input logic [31:0] pc,
                        input logic [31:0] npc, input logic c, input logic [11:0] idx,
                        input logic [31:0] d, input logic m, input logic w);
        rob_bus.rob_head_valid    = v;
        rob_bus.rob_head_excp     = e;
        rob_bus.rob_head_pc       = pc;
        rob_bus.rob_head_next_pc  = npc;
        rob_bus.rob_head_csr_need = c;
        rob_bus.rob_head_csr_idx  = idx;
        rob_bus.rob_head_csr_data = d;
        rob_bus.rob_head_mret     = m;
        rob_bus.rob_head_wfi      = w;
    endtask

    task automatic plain(input logic v);
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        head(v, 16'h0, pc, pc + 32'd4, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Compare every output at the negedge, then advance the model at posedge.
    task automatic run_cycle();
        logic        can, com, irq_ok, fl;
        logic [11:0] pend, sel;
        logic [31:0] base, tgt;
        int          cause;
        bit          redir, to_sleep;
        @(negedge clk);
        can    = !rst && !sleeping && (cyc >= resume_cyc);
        com    = can && rob_bus.rob_head_valid;
        pend   = irq_vec(lines_q) & irq_msk;
        cause  = hi_cause(pend);
        sel    = (cause >= 0) ? (12'd1 << cause) : 12'd0;
        irq_ok = can && (pend != 0) && (rob_bus.rob_head_excp == 0)
                 && !rob_bus.rob_head_mret && !rob_bus.rob_head_csr_need;
        fl     = !rst && (cyc == flush_at);
        chk("pop",      rob_bus.rob_head_pop, com);
        chk("cvalid",   rob_bus.commit_valid, com);
        chk("cexcp",    rob_bus.commit_excp, can ? rob_bus.rob_head_excp : 16'h0);
        chk("cirq",     rob_bus.commit_irq, irq_ok ? sel : 12'h0);
        chk("cpc",      rob_bus.commit_pc, can ? rob_bus.rob_head_pc : 32'h0);
        chk("cnpc",     rob_bus.commit_next_pc, can ? rob_bus.rob_head_next_pc : 32'h0);
        chk("ccsrneed", rob_bus.commit_csr_need, can && rob_bus.rob_head_csr_need);
        chk("ccsridx",  rob_bus.commit_csr_idx, can ? rob_bus.rob_head_csr_idx : 12'h0);
        chk("ccsrdata", rob_bus.commit_csr_data, can ? rob_bus.rob_head_csr_data : 32'h0);
        chk("cmret",    rob_bus.commit_mret_op, can && rob_bus.rob_head_mret);
        chk("flush",    flush, fl);
        chk("redir",    redirect_pc, fl ? flush_pc : 32'h0);
        chk("stall",    fetch_stall, !rst && sleeping);
        @(posedge clk);
        if (rst) begin
            resume_cyc = 0;
            sleeping   = 1'b0;
            flush_at   = -1;
            lines_q    = '0;
        end else begin
            redir    = 1'b0;
            to_sleep = 1'b0;
            tgt      = '0;
            if (sleeping && lines_q != 0) sleeping = 1'b0;
            if (com) begin
                base = csr_mtvec & 32'hFFFF_FFFC;
                if (rob_bus.rob_head_excp != 0) begin
                    redir = 1'b1;
                    tgt   = base;
                end else if (irq_ok) begin
                    redir = 1'b1;
                    tgt   = (csr_mtvec[1:0] == 2'b01) ? base + 32'(4 * cause) : base;
                end else if (rob_bus.rob_head_mret) begin
                    redir = 1'b1;
                    tgt   = csr_mepc;
                end else if (rob_bus.rob_head_csr_need) begin
                    redir = 1'b1;
                    tgt   = rob_bus.rob_head_next_pc;
                end else if (rob_bus.rob_head_wfi) begin
                    redir    = 1'b1;
                    to_sleep = 1'b1;
                    tgt      = rob_bus.rob_head_next_pc;
                end
            end
            if (redir) begin
                flush_at = cyc + 1;
                flush_pc = tgt;
                if (to_sleep) sleeping = 1'b1;
                else resume_cyc = cyc + 1 + int'(FC);
            end
            lines_q = {ext_irq, sft_irq, tmr_irq};
        end
        cyc++;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ext_irq   = 1'b1;
        sft_irq   = 1'b0;
        tmr_irq   = 1'b0;
        irq_msk   = 12'hFFF;
        csr_mepc  = 32'h0000_1000;
        csr_mtvec = {30'h0000_0100, MTVEC_DIRECT};
        plain(1'b1);
        #1;

        // Reset: everything held at zero even with a valid head and an irq line.
        repeat (2) begin
            chk("rst_cvalid", rob_bus.commit_valid, 1'b0);
            chk("rst_cpc", rob_bus.commit_pc, 32'h0);
            run_cycle();
        end
        rst       = 1'b0;
        ext_irq   = 1'b0;
        irq_msk   = 12'h0;
        csr_mtvec = 32'h8000_0001;

        // Three plain commits back to back.
        repeat (3) begin
            plain(1'b1);
            #1;
            chk("plain_cvalid", rob_bus.commit_valid, 1'b1);
            chk("plain_flush", flush, 1'b0);
            run_cycle();
        end

        // Exception: flush to the mtvec base, drain two cycles.
        head(1'b1, 16'h0004, 32'h100, 32'h104, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("exc_commit", rob_bus.commit_valid, 1'b1);
        run_cycle();
        plain(1'b1);
        #1;
        chk("exc_flush", flush, 1'b1);
        chk("exc_redir", redirect_pc, 32'h8000_0000);
        chk("exc_t1_cvalid", rob_bus.commit_valid, 1'b0);
        run_cycle();
        chk("exc_t2_cvalid", rob_bus.commit_valid, 1'b0);
        chk("exc_t2_flush", flush, 1'b0);
        run_cycle();
        chk("exc_t3_cvalid", rob_bus.commit_valid, 1'b1);
        run_cycle();

        // Vectored interrupt: MEI beats MTI, cause 11.
        plain(1'b0);
        ext_irq = 1'b1;
        tmr_irq = 1'b1;
        irq_msk = 12'h880;
        run_cycle();
        plain(1'b1);
        #1;
        chk("irq_sel", rob_bus.commit_irq, 12'h800);
        run_cycle();
        plain(1'b0);
        ext_irq = 1'b0;
        tmr_irq = 1'b0;
        #1;
        chk("irq_flush", flush, 1'b1);
        chk("irq_redir", redirect_pc, 32'h8000_002C);
        repeat (2) run_cycle();
        irq_msk = 12'h0;

        // CSR write serialises through next_pc.
        head(1'b1, 16'h0, 32'h200, 32'h204, 1'b1, 12'h300, 32'hDEAD_BEEF, 1'b0, 1'b0);
        #1;
        chk("csr_idx", rob_bus.commit_csr_idx, 12'h300);
        chk("csr_data", rob_bus.commit_csr_data, 32'hDEAD_BEEF);
        chk("csr_need", rob_bus.commit_csr_need, 1'b1);
        run_cycle();
        plain(1'b1);
        #1;
        chk("csr_flush", flush, 1'b1);
        chk("csr_redir", redirect_pc, 32'h204);
        run_cycle();
        chk("csr_drain", rob_bus.commit_valid, 1'b0);
        run_cycle();
        chk("csr_resume", rob_bus.commit_valid, 1'b1);
        run_cycle();

        // WFI: sleep until an (unmasked) irq line is seen through its register.
        head(1'b1, 16'h0, 32'h3C, 32'h40, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        run_cycle();
        plain(1'b1);
        #1;
        chk("wfi_redir", redirect_pc, 32'h40);
        chk("wfi_stall", fetch_stall, 1'b1);
        repeat (10) run_cycle();
        sft_irq = 1'b1;
        #1;
        chk("wfi_r0_stall", fetch_stall, 1'b1);
        run_cycle();
        chk("wfi_r1_stall", fetch_stall, 1'b1);
        run_cycle();
        sft_irq = 1'b0;
        #1;
        chk("wfi_r2_stall", fetch_stall, 1'b0);
        chk("wfi_r2_commit", rob_bus.commit_valid, 1'b1);
        run_cycle();

        // Reset in the middle of a drain window.
        head(1'b1, 16'h0100, 32'h500, 32'h504, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
        run_cycle();
        plain(1'b1);
        run_cycle();
        rst = 1'b1;
        #1;
        chk("rstd_cvalid", rob_bus.commit_valid, 1'b0);
        chk("rstd_flush", flush, 1'b0);
        run_cycle();
        rst = 1'b0;
        plain(1'b1);
        #1;
        chk("rstd_resume", rob_bus.commit_valid, 1'b1);
        run_cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] pc;
            rst = ($urandom_range(0, 63) == 0);
            pc  = $urandom & 32'hFFFF_FFFC;
            head(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0) ? 16'(32'd1 << $urandom_range(0, 15)) : 16'h0,
                 pc, pc + 32'd4,
                 ($urandom_range(0, 9) == 0), 12'($urandom), $urandom,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0));
            ext_irq   = ($urandom_range(0, 9) == 0);
            sft_irq   = ($urandom_range(0, 9) == 0);
            tmr_irq   = ($urandom_range(0, 9) == 0);
            irq_msk   = 12'($urandom);
            csr_mepc  = $urandom;
            csr_mtvec = $urandom;
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
